// File: rtl/mem_pkg.sv
// Shared definitions for the memory stage: control-word field positions, write-back
// source and access-size encodings, FSM states and the misalignment predicate.
package mem_pkg;

   localparam int CTRL_W_DEF = 8;

   localparam int C_F3_LSB    = 0;
   localparam int C_F3_MSB    = 2;
   localparam int C_MEM_READ  = 3;
   localparam int C_MEM_WRITE = 4;
   localparam int C_REG_WRITE = 5;
   localparam int C_WBSEL_LSB = 6;
   localparam int C_WBSEL_MSB = 7;

   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;
   localparam logic [1:0] WB_PC  = 2'b10;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic {
      S_IDLE,
      S_ACCESS
   } state_t;

   // Halfwords need an even offset, words a zero offset; bytes are always aligned.
   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
      logic mis;
      mis = 1'b0;
      case (f3[1:0])
         2'b01:   mis = off[0];
         2'b10:   mis = (off != 2'b00);
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store byte-enables/replicated data and load extract/extend.
// Zero latency; no flow control.
module mem_lane_align
   import mem_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] st_data_i,
   input  logic [31:0] ld_word_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] ld_data_o
);

   logic [31:0] ld_shift;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   assign ld_shift = ld_word_i >> {off_i, 3'b000};
   assign ld_byte  = ld_shift[7:0];
   assign ld_half  = off_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];

   always_comb begin
      be_o    = 4'b1111;
      wdata_o = st_data_i;
      case (funct3_i[1:0])
         2'b00: begin
            be_o    = 4'b0001 << off_i;
            wdata_o = {4{st_data_i[7:0]}};
         end
         2'b01: begin
            be_o    = off_i[1] ? 4'b1100 : 4'b0011;
            wdata_o = {2{st_data_i[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      ld_data_o = ld_word_i;
      case (funct3_i)
         F3_LB:   ld_data_o = {{24{ld_byte[7]}}, ld_byte};
         F3_LH:   ld_data_o = {{16{ld_half[15]}}, ld_half};
         F3_LBU:  ld_data_o = {24'h0, ld_byte};
         F3_LHU:  ld_data_o = {16'h0, ld_half};
         default: ld_data_o = ld_word_i;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: 1-cycle write-back for ALU/PC ops, loads/stores held in ACCESS until dmem_ack_i;
// mem_ready_o low stalls execute while busy. MEM_MISALIGN_TRAP_EN adds misaligned-access trapping.
module mem_stage
   import mem_pkg::*;
#(
   parameter int CTRL_W = CTRL_W_DEF,
   parameter int XLEN   = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [CTRL_W-1:0] ex_control_i,
   input  logic [XLEN-1:0]   ex_aluResult_i,
   input  logic [XLEN-1:0]   ex_data_i,
   input  logic [31:0]       ex_rd_addr_i,
   input  logic [XLEN-1:0]   ex_pcplus_i,
   output logic              mem_ready_o,
   output logic              dmem_req_o,
   output logic              dmem_we_o,
   output logic [XLEN-1:0]   dmem_addr_o,
   output logic [XLEN-1:0]   dmem_wdata_o,
   output logic [3:0]        dmem_be_o,
   input  logic              dmem_ack_i,
   input  logic [XLEN-1:0]   dmem_rdata_i,
   output logic [4:0]        wb_rd_addr_o,
   output logic [XLEN-1:0]   wb_rd_o,
   output logic              wb_rd_en_o
`ifdef MEM_MISALIGN_TRAP_EN
   ,
   output logic              misalign_o,
   output logic [XLEN-1:0]   misalign_addr_o
`endif
);

   state_t            state_q, state_d;
   logic [2:0]        f3_q, f3_d;
   logic [XLEN-1:0]   addr_q, addr_d;
   logic [XLEN-1:0]   data_q, data_d;
   logic [4:0]        rd_q, rd_d;
   logic              we_q, we_d;
   logic              rw_q, rw_d;
   logic [4:0]        wb_addr_q, wb_addr_d;
   logic [XLEN-1:0]   wb_data_q, wb_data_d;
   logic              wb_en_q, wb_en_d;
   logic              mis_q, mis_d;
   logic [XLEN-1:0]   mis_addr_q, mis_addr_d;

   logic [2:0]        ex_f3;
   logic [1:0]        ex_wbsel;
   logic              ex_mem_op;
   logic [4:0]        ex_rd;
   logic [XLEN-1:0]   ex_wb_val;
   logic [3:0]        lane_be;
   logic [XLEN-1:0]   lane_wdata;
   logic [XLEN-1:0]   lane_ld;
   logic              unused_rd_hi;

   assign ex_f3     = ex_control_i[C_F3_MSB:C_F3_LSB];
   assign ex_wbsel  = ex_control_i[C_WBSEL_MSB:C_WBSEL_LSB];
   assign ex_mem_op = ex_control_i[C_MEM_READ] | ex_control_i[C_MEM_WRITE];
   assign ex_rd     = ex_rd_addr_i[4:0];
   assign ex_wb_val = (ex_wbsel == WB_PC) ? ex_pcplus_i : ex_aluResult_i;
   assign unused_rd_hi = ^ex_rd_addr_i[31:5];

   mem_lane_align u_lane (
      .funct3_i  (f3_q),
      .off_i     (addr_q[1:0]),
      .st_data_i (data_q),
      .ld_word_i (dmem_rdata_i),
      .be_o      (lane_be),
      .wdata_o   (lane_wdata),
      .ld_data_o (lane_ld)
   );

   always_comb begin
      state_d    = state_q;
      f3_d       = f3_q;
      addr_d     = addr_q;
      data_d     = data_q;
      rd_d       = rd_q;
      we_d       = we_q;
      rw_d       = rw_q;
      wb_addr_d  = wb_addr_q;
      wb_data_d  = wb_data_q;
      wb_en_d    = 1'b0;
      mis_d      = 1'b0;
      mis_addr_d = mis_addr_q;
      case (state_q)
         S_IDLE: begin
            if (ex_mem_op) begin
`ifdef MEM_MISALIGN_TRAP_EN
               if (is_misaligned(ex_f3, ex_aluResult_i[1:0])) begin
                  mis_d      = 1'b1;
                  mis_addr_d = ex_aluResult_i;
               end else begin
`else
               begin
`endif
                  state_d = S_ACCESS;
                  f3_d    = ex_f3;
                  addr_d  = ex_aluResult_i;
                  data_d  = ex_data_i;
                  rd_d    = ex_rd;
                  we_d    = ex_control_i[C_MEM_WRITE];
                  rw_d    = ex_control_i[C_REG_WRITE];
               end
            end else if (ex_control_i[C_REG_WRITE] && (ex_rd != 5'd0)) begin
               wb_en_d   = 1'b1;
               wb_addr_d = ex_rd;
               wb_data_d = ex_wb_val;
            end
         end
         S_ACCESS: begin
            // Request fields are frozen in the _q copies until the ack edge.
            if (dmem_ack_i) begin
               state_d = S_IDLE;
               if (!we_q && rw_q && (rd_q != 5'd0)) begin
                  wb_en_d   = 1'b1;
                  wb_addr_d = rd_q;
                  wb_data_d = lane_ld;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= S_IDLE;
         f3_q       <= 3'd0;
         addr_q     <= '0;
         data_q     <= '0;
         rd_q       <= 5'd0;
         we_q       <= 1'b0;
         rw_q       <= 1'b0;
         wb_addr_q  <= 5'd0;
         wb_data_q  <= '0;
         wb_en_q    <= 1'b0;
         mis_q      <= 1'b0;
         mis_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         f3_q       <= f3_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         rd_q       <= rd_d;
         we_q       <= we_d;
         rw_q       <= rw_d;
         wb_addr_q  <= wb_addr_d;
         wb_data_q  <= wb_data_d;
         wb_en_q    <= wb_en_d;
         mis_q      <= mis_d;
         mis_addr_q <= mis_addr_d;
      end
   end

   assign mem_ready_o  = (state_q == S_IDLE);
   assign dmem_req_o   = (state_q == S_ACCESS);
   assign dmem_we_o    = dmem_req_o & we_q;
   assign dmem_addr_o  = dmem_req_o ? {addr_q[XLEN-1:2], 2'b00} : '0;
   assign dmem_be_o    = dmem_req_o ? lane_be : 4'b0000;
   assign dmem_wdata_o = dmem_req_o ? lane_wdata : '0;
   assign wb_rd_addr_o = wb_addr_q;
   assign wb_rd_o      = wb_data_q;
   assign wb_rd_en_o   = wb_en_q;

`ifdef MEM_MISALIGN_TRAP_EN
   assign misalign_o      = mis_q;
   assign misalign_addr_o = mis_addr_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: scoreboard of expected write-backs plus per-scenario checks.
module tb_mem_stage;

   logic        clk_i;
   logic        rst_i;
   logic [7:0]  ex_control_i;
   logic [31:0] ex_aluResult_i;
   logic [31:0] ex_data_i;
   logic [31:0] ex_rd_addr_i;
   logic [31:0] ex_pcplus_i;
   logic        mem_ready_o;
   logic        dmem_req_o;
   logic        dmem_we_o;
   logic [31:0] dmem_addr_o;
   logic [31:0] dmem_wdata_o;
   logic [3:0]  dmem_be_o;
   logic        dmem_ack_i;
   logic [31:0] dmem_rdata_i;
   logic [4:0]  wb_rd_addr_o;
   logic [31:0] wb_rd_o;
   logic        wb_rd_en_o;
`ifdef MEM_MISALIGN_TRAP_EN
   logic        misalign_o;
   logic [31:0] misalign_addr_o;
`endif

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } wb_t;

   wb_t exp_q[$];
   int  errors = 0;
   int  checks = 0;

   mem_stage dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .ex_control_i   (ex_control_i),
      .ex_aluResult_i (ex_aluResult_i),
      .ex_data_i      (ex_data_i),
      .ex_rd_addr_i   (ex_rd_addr_i),
      .ex_pcplus_i    (ex_pcplus_i),
      .mem_ready_o    (mem_ready_o),
      .dmem_req_o     (dmem_req_o),
      .dmem_we_o      (dmem_we_o),
      .dmem_addr_o    (dmem_addr_o),
      .dmem_wdata_o   (dmem_wdata_o),
      .dmem_be_o      (dmem_be_o),
      .dmem_ack_i     (dmem_ack_i),
      .dmem_rdata_i   (dmem_rdata_i),
      .wb_rd_addr_o   (wb_rd_addr_o),
      .wb_rd_o        (wb_rd_o),
      .wb_rd_en_o     (wb_rd_en_o)
`ifdef MEM_MISALIGN_TRAP_EN
      ,
      .misalign_o     (misalign_o),
      .misalign_addr_o(misalign_addr_o)
`endif
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Control word layout: {wb_sel[1:0], reg_write, mem_write, mem_read, funct3[2:0]}
   function automatic logic [7:0] mk(input logic [1:0] wbs, input logic rw, input logic wr,
                                     input logic rdm, input logic [2:0] f3);
      return {wbs, rw, wr, rdm, f3};
   endfunction

   task automatic drive(input logic [7:0] c, input logic [31:0] alu, input logic [31:0] dat,
                        input logic [31:0] rd, input logic [31:0] pc);
      ex_control_i   = c;
      ex_aluResult_i = alu;
      ex_data_i      = dat;
      ex_rd_addr_i   = rd;
      ex_pcplus_i    = pc;
   endtask

   task automatic bubble();
      drive(8'h00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd31, 32'hFFFF_FFFF);
   endtask

   // Advance one clock; any write-back pulse is popped against the scoreboard.
   task automatic cycle();
      wb_t e;
      @(posedge clk_i);
      #1;
      if (wb_rd_en_o === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL wb_unexpected: got rd=%0d data=%h, expected no write-back",
                     wb_rd_addr_o, wb_rd_o);
         end else begin
            e = exp_q.pop_front();
            if (wb_rd_addr_o !== e.a || wb_rd_o !== e.d) begin
               errors++;
               $display("FAIL wb_data: got rd=%0d data=%h, expected rd=%0d data=%h",
                        wb_rd_addr_o, wb_rd_o, e.a, e.d);
            end
         end
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b0;
      dmem_ack_i = 1'b0;
      dmem_rdata_i = 32'h0;
      bubble();
      #12;
      checks++;
      if ({mem_ready_o, dmem_req_o, dmem_we_o, wb_rd_en_o} !== 4'b1000) begin
         errors++;
         $display("FAIL reset_ctrl: got ready/req/we/wben=%b, expected 1000",
                  {mem_ready_o, dmem_req_o, dmem_we_o, wb_rd_en_o});
      end
      checks++;
      if (wb_rd_o !== 32'h0 || wb_rd_addr_o !== 5'd0 || dmem_addr_o !== 32'h0 ||
          dmem_be_o !== 4'h0 || dmem_wdata_o !== 32'h0) begin
         errors++;
         $display("FAIL reset_data: got wb=%h rd=%0d addr=%h be=%b wdata=%h, expected all zero",
                  wb_rd_o, wb_rd_addr_o, dmem_addr_o, dmem_be_o, dmem_wdata_o);
      end
      @(negedge clk_i);
      rst_i = 1'b1;
      cycle();
   endtask

   task automatic test_alu();
      drive(mk(2'b00, 1'b1, 1'b0, 1'b0, 3'd0), 32'h1234, 32'h0, 32'd5, 32'h8);
      exp_q.push_back('{a: 5'd5, d: 32'h1234});
      cycle();
      checks++;
      if (wb_rd_en_o !== 1'b1 || mem_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL alu_pulse: got wben=%b ready=%b, expected 1 1", wb_rd_en_o, mem_ready_o);
      end
      bubble();
      cycle();
      checks++;
      if (wb_rd_en_o !== 1'b0 || wb_rd_o !== 32'h1234) begin
         errors++;
         $display("FAIL bubble_hold: got wben=%b wb=%h, expected 0 00001234", wb_rd_en_o, wb_rd_o);
      end
      drive(mk(2'b11, 1'b1, 1'b0, 1'b0, 3'd0), 32'h55, 32'h0, 32'd7, 32'h99);
      exp_q.push_back('{a: 5'd7, d: 32'h55});
      cycle();
      bubble();
      cycle();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL alu_drain: got %0d pending write-backs, expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_jal();
      drive(mk(2'b10, 1'b1, 1'b0, 1'b0, 3'd0), 32'h999, 32'h0, 32'd1, 32'h44);
      exp_q.push_back('{a: 5'd1, d: 32'h44});
      cycle();
      drive(mk(2'b10, 1'b1, 1'b0, 1'b0, 3'd0), 32'h999, 32'h0, 32'd0, 32'h88);
      cycle();
      checks++;
      if (wb_rd_en_o !== 1'b0 || wb_rd_o !== 32'h44) begin
         errors++;
         $display("FAIL jal_rd0: got wben=%b wb=%h, expected 0 00000044", wb_rd_en_o, wb_rd_o);
      end
      bubble();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL jal_drain: got %0d pending write-backs, expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] dat,
                             input logic [3:0] exp_be, input logic [31:0] exp_wd, input int lat);
      drive(mk(2'b00, 1'b1, 1'b1, 1'b0, f3), addr, dat, 32'd3, 32'h0);
      cycle();
      bubble();
      for (int i = 1; i <= lat; i++) begin
         checks++;
         if ({mem_ready_o, dmem_req_o, dmem_we_o} !== 3'b011 || dmem_addr_o !== {addr[31:2], 2'b00} ||
             dmem_be_o !== exp_be || dmem_wdata_o !== exp_wd) begin
            errors++;
            $display("FAIL store_req f3=%0d cyc=%0d: got rdy/req/we=%b addr=%h be=%b wd=%h, expected 011 %h %b %h",
                     f3, i, {mem_ready_o, dmem_req_o, dmem_we_o}, dmem_addr_o, dmem_be_o, dmem_wdata_o,
                     {addr[31:2], 2'b00}, exp_be, exp_wd);
         end
         dmem_ack_i = (i == lat);
         cycle();
      end
      dmem_ack_i = 1'b0;
      checks++;
      if (mem_ready_o !== 1'b1 || dmem_req_o !== 1'b0) begin
         errors++;
         $display("FAIL store_done f3=%0d: got ready=%b req=%b, expected 1 0", f3, mem_ready_o, dmem_req_o);
      end
   endtask

   task automatic test_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata,
                            input logic [4:0] rd, input logic [31:0] expd, input int extra);
      drive(mk(2'b01, 1'b1, 1'b0, 1'b1, f3), addr, 32'h0, {27'h0, rd}, 32'h0);
      if (rd != 5'd0) exp_q.push_back('{a: rd, d: expd});
      cycle();
      bubble();
      checks++;
      if ({mem_ready_o, dmem_req_o, dmem_we_o} !== 3'b010 || dmem_addr_o !== {addr[31:2], 2'b00}) begin
         errors++;
         $display("FAIL load_req f3=%0d: got rdy/req/we=%b addr=%h, expected 010 %h",
                  f3, {mem_ready_o, dmem_req_o, dmem_we_o}, dmem_addr_o, {addr[31:2], 2'b00});
      end
      for (int i = 0; i < extra; i++) cycle();
      dmem_ack_i = 1'b1;
      dmem_rdata_i = rdata;
      cycle();
      dmem_ack_i = 1'b0;
      dmem_rdata_i = 32'h0;
      checks++;
      if (exp_q.size() != 0 || mem_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL load_done f3=%0d: got pending=%0d ready=%b, expected 0 1", f3, exp_q.size(), mem_ready_o);
         exp_q.delete();
      end
   endtask

   task automatic test_idle_ack();
      dmem_ack_i = 1'b1;
      dmem_rdata_i = 32'hDEAD_BEEF;
      cycle();
      cycle();
      checks++;
      if (dmem_req_o !== 1'b0 || mem_ready_o !== 1'b1 || wb_rd_en_o !== 1'b0) begin
         errors++;
         $display("FAIL idle_ack: got req=%b ready=%b wben=%b, expected 0 1 0", dmem_req_o, mem_ready_o, wb_rd_en_o);
      end
      dmem_ack_i = 1'b0;
      dmem_rdata_i = 32'h0;
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         drive(mk(2'b00, 1'b1, 1'b0, 1'b0, 3'd0), 32'hA000 + i, 32'h0, 32'd10 + i, 32'h0);
         exp_q.push_back('{a: 5'(10 + i), d: 32'hA000 + i});
         cycle();
      end
      test_load(3'b010, 32'h20, 32'hCAFE_F00D, 5'd2, 32'hCAFE_F00D, 0);
      drive(mk(2'b00, 1'b1, 1'b0, 1'b0, 3'd0), 32'h77, 32'h0, 32'd9, 32'h0);
      exp_q.push_back('{a: 5'd9, d: 32'h77});
      cycle();
      bubble();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL b2b_drain: got %0d pending write-backs, expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset_abort();
      drive(mk(2'b01, 1'b1, 1'b0, 1'b1, 3'b010), 32'h40, 32'h0, 32'd6, 32'h0);
      cycle();
      bubble();
      checks++;
      if (dmem_req_o !== 1'b1) begin
         errors++;
         $display("FAIL abort_pre: got req=%b, expected 1", dmem_req_o);
      end
      #2 rst_i = 1'b0;
      #1;
      checks++;
      if (dmem_req_o !== 1'b0 || mem_ready_o !== 1'b1 || wb_rd_en_o !== 1'b0) begin
         errors++;
         $display("FAIL abort_async: got req=%b ready=%b wben=%b, expected 0 1 0", dmem_req_o, mem_ready_o, wb_rd_en_o);
      end
      dmem_ack_i = 1'b1;
      dmem_rdata_i = 32'h1111_2222;
      cycle();
      @(negedge clk_i);
      rst_i = 1'b1;
      cycle();
      dmem_ack_i = 1'b0;
      cycle();
      checks++;
      if (wb_rd_en_o !== 1'b0 || mem_ready_o !== 1'b1 || wb_rd_o !== 32'h0) begin
         errors++;
         $display("FAIL abort_after: got wben=%b ready=%b wb=%h, expected 0 1 00000000", wb_rd_en_o, mem_ready_o, wb_rd_o);
      end
   endtask

   task automatic test_misalign();
`ifdef MEM_MISALIGN_TRAP_EN
      drive(mk(2'b01, 1'b1, 1'b0, 1'b1, 3'b010), 32'h101, 32'h0, 32'd4, 32'h0);
      cycle();
      bubble();
      checks++;
      if (misalign_o !== 1'b1 || misalign_addr_o !== 32'h101 || dmem_req_o !== 1'b0 || mem_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL misalign_trap: got mis=%b addr=%h req=%b ready=%b, expected 1 00000101 0 1",
                  misalign_o, misalign_addr_o, dmem_req_o, mem_ready_o);
      end
      cycle();
      checks++;
      if (misalign_o !== 1'b0 || dmem_req_o !== 1'b0 || wb_rd_en_o !== 1'b0) begin
         errors++;
         $display("FAIL misalign_pulse: got mis=%b req=%b wben=%b, expected 0 0 0", misalign_o, dmem_req_o, wb_rd_en_o);
      end
`else
      test_load(3'b010, 32'h101, 32'h89AB_CDEF, 5'd4, 32'h89AB_CDEF, 1);
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_alu();
      test_jal();
      test_store(3'b000, 32'h103, 32'h0000_00AB, 4'b1000, 32'hABAB_ABAB, 3);
      test_store(3'b001, 32'h002, 32'h5555_1234, 4'b1100, 32'h1234_1234, 1);
      test_store(3'b010, 32'h008, 32'h0BAD_F00D, 4'b1111, 32'h0BAD_F00D, 2);
      test_idle_ack();
      test_load(3'b000, 32'h102, 32'h0080_0000, 5'd8, 32'hFFFF_FF80, 0);
      test_load(3'b100, 32'h102, 32'h0080_0000, 5'd8, 32'h0000_0080, 1);
      test_load(3'b001, 32'h002, 32'h8001_ABCD, 5'd12, 32'hFFFF_8001, 0);
      test_load(3'b101, 32'h002, 32'h8001_ABCD, 5'd12, 32'h0000_8001, 2);
      test_load(3'b000, 32'h001, 32'h0000_7F00, 5'd13, 32'h0000_007F, 0);
      test_load(3'b010, 32'h008, 32'hDEAD_BEEF, 5'd0, 32'h0, 0);
      test_back_to_back();
      test_misalign();
      test_reset_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
